i2c_responder: RTL and testbench

Synthesizable I2C target (slave). It is the far end of the I2C_Driver master and serves a byte-addressed register space through a simple parallel port. It is used as an on-board loopback target for driver bring-up, and as the target half when a second board reads flight sensor data over I2C. 7-bit addressing, standard/fast mode, no clock stretching.

---
 rtl/i2c_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_responder.sv
// ============================================================================
// Module   : i2c_responder
// Brief    : I2C target (7-bit address, no clock stretching) serving a
//            byte-addressed register space through a parallel port.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h60,
    parameter int         PTR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             wr_en,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] ptr,
    input  logic [7:0]       rd_data,
    output logic             busy,
    output logic             ack_err
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RACK      = 4'd8,
        S_WAIT_STOP = 4'd9
    } state_t;

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    state_t           r_state;
    logic             r_scl_s1, r_scl_s2, r_scl_d;
    logic             r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_rw;
    logic             r_sda_oe;
    logic             r_wr_en;
    logic [7:0]       r_wr_data;
    logic [PTR_W-1:0] r_ptr;
    logic             r_inc_pend;
    logic             r_ack_err;
    logic             r_mack;
    logic             r_nack_seen;
    logic             r_extra;

    logic             w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]       w_byte;

    // START/STOP require SCL high on both the synced and history sample
    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1    <= 1'b1;
            r_scl_s2    <= 1'b1;
            r_scl_d     <= 1'b1;
            r_sda_s1    <= 1'b1;
            r_sda_s2    <= 1'b1;
            r_sda_d     <= 1'b1;
            r_state     <= S_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_rw        <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= 8'd0;
            r_ptr       <= '0;
            r_inc_pend  <= 1'b0;
            r_ack_err   <= 1'b0;
            r_mack      <= 1'b0;
            r_nack_seen <= 1'b0;
            r_extra     <= 1'b0;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
            r_wr_en  <= 1'b0;

            // write strobe carries the pre-increment pointer
            if (r_inc_pend) begin
                r_ptr      <= r_ptr + c_ptr_one;
                r_inc_pend <= 1'b0;
            end

            if (w_start) begin
                r_state     <= S_ADDR;
                r_bit_cnt   <= 4'd0;
                r_sda_oe    <= 1'b0;
                r_ack_err   <= 1'b0;
                r_mack      <= 1'b0;
                r_nack_seen <= 1'b0;
                r_extra     <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_mack    <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                if (r_state == S_ADDR) begin
                                    r_rw <= w_byte[0];
                                    if (w_byte[7:1] == DEV_ADDR && w_byte[7:1] != 7'd0) begin
                                        r_state <= S_ADDR_ACK;
                                    end else begin
                                        r_state     <= S_WAIT_STOP;
                                        r_nack_seen <= 1'b0;
                                    end
                                end else if (r_state == S_PTR) begin
                                    r_ptr   <= PTR_W'(w_byte);
                                    r_state <= S_PTR_ACK;
                                end else begin
                                    r_wr_data  <= w_byte;
                                    r_wr_en    <= 1'b1;
                                    r_inc_pend <= 1'b1;
                                    r_state    <= S_WDATA_ACK;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    // first fall drives the ACK, second fall releases it
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_shift   <= {rd_data[6:0], 1'b0};
                                    r_sda_oe  <= ~rd_data[7];
                                    r_bit_cnt <= 4'd1;
                                    r_state   <= S_RDATA;
                                end else if (r_state == S_ADDR_ACK) begin
                                    r_state <= S_PTR;
                                end else begin
                                    r_state <= S_WDATA;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_RACK;
                            end else begin
                                r_sda_oe  <= ~r_shift[7];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_RACK: begin
                        if (w_scl_rise && !r_mack) begin
                            r_ptr <= r_ptr + c_ptr_one;
                            if (!r_sda_s2) begin
                                r_mack <= 1'b1;
                            end else begin
                                r_state     <= S_WAIT_STOP;
                                r_nack_seen <= 1'b1;
                                r_extra     <= 1'b0;
                            end
                        end else if (w_scl_fall && r_mack) begin
                            r_mack    <= 1'b0;
                            r_shift   <= {rd_data[6:0], 1'b0};
                            r_sda_oe  <= ~rd_data[7];
                            r_bit_cnt <= 4'd1;
                            r_state   <= S_RDATA;
                        end
                    end
                    S_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                        // one rise is the STOP setup; a second is a protocol error
                        if (w_scl_rise && r_nack_seen) begin
                            if (r_extra) begin
                                r_ack_err <= 1'b1;
                            end else begin
                                r_extra <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe  = r_sda_oe;
    assign wr_en   = r_wr_en;
    assign wr_data = r_wr_data;
    assign ptr     = r_ptr;
    assign busy    = (r_state != S_IDLE) && (r_state != S_WAIT_STOP);
    assign ack_err = r_ack_err;

endmodule

`default_nettype wire

// File: tb/tb_i2c_responder.sv
// ============================================================================
// Module   : tb_i2c_responder
// Brief    : Directed bench for i2c_responder: bus master tasks, a table of
//            write/address vectors and hand sequences for read/abort/reset.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_responder;

    localparam int c_q = 200;   // quarter SCL period in ns

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       m_sda;
    logic       sda_line;
    logic       sda_oe;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] ptr;
    logic [7:0] rd_data;
    logic       busy;
    logic       ack_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] p;
        logic [7:0] d;
    } wr_t;
    wr_t wr_log[$];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] pbyte;
        int         nd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
        int         exp_nwr;
        logic [7:0] exp_wp0;
        logic [7:0] exp_wp1;
        logic [7:0] exp_ptr;
    } vec_t;

    assign sda_line = m_sda & ~sda_oe;
    assign rd_data  = ptr ^ 8'hFF;

    i2c_responder #(.DEV_ADDR(7'h60), .PTR_W(8)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .ptr     (ptr),
        .rd_data (rd_data),
        .busy    (busy),
        .ack_err (ack_err)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(negedge clk) begin
        if (wr_en) wr_log.push_back('{p: ptr, d: wr_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_start();
        m_sda = 1'b1; #c_q;
        scl   = 1'b1; #c_q;
        m_sda = 1'b0; #c_q;
        scl   = 1'b0; #c_q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #c_q;
        scl   = 1'b1; #c_q;
        m_sda = 1'b1; #c_q;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #c_q;
        scl   = 1'b1; #(2*c_q);
        scl   = 1'b0; #c_q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; #c_q;
        scl   = 1'b1; #c_q;
        acked = ~sda_line; #c_q;
        scl   = 1'b0; #c_q;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; #c_q;
            scl   = 1'b1; #c_q;
            b[i]  = sda_line; #c_q;
            scl   = 1'b0; #c_q;
        end
        send_bit(nack);
    endtask

    vec_t       vecs[4];
    logic       a;
    logic [7:0] rb;

    initial begin
        vecs[0] = '{8'hC0, 8'h10, 2, 8'hA5, 8'h3C, 1'b1, 2, 8'h10, 8'h11, 8'h12};
        vecs[1] = '{8'hC2, 8'h05, 0, 8'h00, 8'h00, 1'b0, 0, 8'h00, 8'h00, 8'h12};
        vecs[2] = '{8'hC0, 8'hFF, 2, 8'h11, 8'h22, 1'b1, 2, 8'hFF, 8'h00, 8'h01};
        vecs[3] = '{8'h00, 8'h33, 1, 8'h77, 8'h00, 1'b0, 0, 8'h00, 8'h00, 8'h01};

        rst_n = 1'b0;
        scl   = 1'b1;
        m_sda = 1'b1;
        repeat (5) @(negedge clk);
        check("rst sda_oe", sda_oe, 0);
        check("rst wr_en", wr_en, 0);
        check("rst wr_data", wr_data, 0);
        check("rst ptr", ptr, 0);
        check("rst busy", busy, 0);
        check("rst ack_err", ack_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            wr_log.delete();
            bus_start();
            write_byte(vecs[v].addr, a);
            check($sformatf("v%0d addr ack", v), a, vecs[v].exp_ack);
            check($sformatf("v%0d busy", v), busy, vecs[v].exp_ack);
            write_byte(vecs[v].pbyte, a);
            check($sformatf("v%0d ptr ack", v), a, vecs[v].exp_ack);
            if (vecs[v].nd > 0) begin
                write_byte(vecs[v].d0, a);
                check($sformatf("v%0d d0 ack", v), a, vecs[v].exp_ack);
            end
            if (vecs[v].nd > 1) begin
                write_byte(vecs[v].d1, a);
                check($sformatf("v%0d d1 ack", v), a, vecs[v].exp_ack);
            end
            bus_stop();
            check($sformatf("v%0d idle busy", v), busy, 0);
            check($sformatf("v%0d idle sda_oe", v), sda_oe, 0);
            check($sformatf("v%0d final ptr", v), ptr, vecs[v].exp_ptr);
            check($sformatf("v%0d wr count", v), wr_log.size(), vecs[v].exp_nwr);
            if (wr_log.size() > 0 && vecs[v].exp_nwr > 0) begin
                check($sformatf("v%0d wr0 ptr", v), wr_log[0].p, vecs[v].exp_wp0);
                check($sformatf("v%0d wr0 data", v), wr_log[0].d, vecs[v].d0);
            end
            if (wr_log.size() > 1 && vecs[v].exp_nwr > 1) begin
                check($sformatf("v%0d wr1 ptr", v), wr_log[1].p, vecs[v].exp_wp1);
                check($sformatf("v%0d wr1 data", v), wr_log[1].d, vecs[v].d1);
            end
        end

        // read with repeated start, master ACK then NACK
        wr_log.delete();
        bus_start();
        write_byte(8'hC0, a);  check("rd addr ack", a, 1);
        write_byte(8'h20, a);  check("rd ptr ack", a, 1);
        bus_start();
        write_byte(8'hC1, a);  check("rd raddr ack", a, 1);
        read_byte(rb, 1'b0);   check("rd byte0", rb, 8'hDF);
        read_byte(rb, 1'b1);   check("rd byte1", rb, 8'hDE);
        bus_stop();
        check("rd final ptr", ptr, 8'h22);
        check("rd ack_err", ack_err, 0);
        check("rd no wr", wr_log.size(), 0);
        check("rd busy", busy, 0);

        // abort mid data byte
        wr_log.delete();
        bus_start();
        write_byte(8'hC0, a);
        write_byte(8'h40, a);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus_stop();
        check("abort wr count", wr_log.size(), 0);
        check("abort ptr", ptr, 8'h40);
        check("abort sda_oe", sda_oe, 0);
        check("abort busy", busy, 0);

        // NACK followed by two extra clocks before STOP
        bus_start();
        write_byte(8'hC1, a);  check("err addr ack", a, 1);
        read_byte(rb, 1'b1);   check("err byte", rb, 8'hBF);
        send_bit(1'b1);
        send_bit(1'b1);
        bus_stop();
        check("err ack_err set", ack_err, 1);
        check("err ptr", ptr, 8'h41);
        bus_start();
        check("err ack_err clr", ack_err, 0);
        bus_stop();

        // async reset while driving a read bit
        bus_start();
        write_byte(8'hC0, a);
        write_byte(8'h80, a);
        bus_start();
        write_byte(8'hC1, a);
        check("ar pre sda_oe", sda_oe, 1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar sda_oe", sda_oe, 0);
        check("ar ptr", ptr, 0);
        check("ar wr_data", wr_data, 0);
        check("ar wr_en", wr_en, 0);
        check("ar busy", busy, 0);
        check("ar ack_err", ack_err, 0);
        scl   = 1'b1;
        m_sda = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
